stream_buffer: RTL and testbench
================================

STREAM_BUFFER -- requirements
Module: stream_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload width in bits (1..256).
REQ-002 SHALL have parameter DEPTH, default 4, entry count; power of two, 2..256.
REQ-003 SHALL have parameter AFULL_LEVEL, default DEPTH-1, level at or above which almost_full asserts.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port stream_in_valid  input  1  upstream word present.
REQ-007 SHALL have port stream_in_ready  output  1  buffer can accept a word.
REQ-008 SHALL have port stream_in_data  input  DATA_WIDTH  upstream payload.
REQ-009 SHALL have port stream_out_ready  input  1  downstream accepts a word.
REQ-010 SHALL have port stream_out_valid  output  1  buffer presents a word.
REQ-011 SHALL have port stream_out_data  output  DATA_WIDTH  head-of-buffer payload.
REQ-012 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 SHALL have port almost_full  output  1  registered, high when level >= AFULL_LEVEL.

Function
REQ-014 SHALL accept a word on any rising edge with stream_in_valid && stream_in_ready (push).
REQ-015 SHALL complete a transfer on any rising edge with stream_out_valid && stream_out_ready (pop).
REQ-016 SHALL drive stream_in_ready = (level < DEPTH); no pass-through of a same-cycle pop while full.
REQ-017 SHALL drive stream_out_valid = (level != 0), and SHALL present words in push order.
REQ-018 SHALL give 1-cycle latency: a word pushed at edge N into an empty buffer is valid after edge N.
REQ-019 SHALL hold stream_out_data stable and stream_out_valid high while stream_out_ready is low.
REQ-020 SHALL track states EMPTY (level 0), PARTIAL, FULL (level DEPTH); push-only +1, pop-only -1, push+pop or neither: level unchanged.
REQ-021 SHALL, on simultaneous push and pop in PARTIAL, keep level constant and advance both pointers.
REQ-022 SHALL wrap read and write pointers modulo DEPTH with no gap or duplicate at the boundary.
REQ-023 SHALL ignore stream_in_data when no push occurs; stream_out_data is don't-care when stream_out_valid is low.

Reset
REQ-024 SHALL, while reset_n is low, force level=0, pointers=0, stream_out_valid=0, stream_in_ready=0, almost_full=0; storage contents are not reset.
REQ-025 SHALL raise stream_in_ready on the first rising edge after reset_n deasserts.
REQ-026 SHALL discard all buffered words when reset asserts mid-operation; no word emerges after reset.

Configuration
REQ-027 SHALL compile statistics logic only when macro STREAM_BUFFER_STATS_EN is defined.
REQ-028 With STREAM_BUFFER_STATS_EN: SHALL add outputs push_count (32) counting pushes and stall_count (32) counting cycles with stream_out_valid && !stream_out_ready; both saturate at all-ones and reset to 0.
REQ-029 Without STREAM_BUFFER_STATS_EN: these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 SHALL place in package stream_buffer_pkg the constant STATS_CNT_WIDTH=32 and a level-width helper function.
REQ-031 SHALL implement storage in sub-module stream_buffer_mem: one write port, one asynchronous read port, parameterised by DATA_WIDTH and DEPTH.

Verification
REQ-032 Reset check: assert reset_n low with level 3 -> level=0, stream_out_valid=0; one edge after release -> stream_in_ready=1.
REQ-033 Latency/order check: with DEPTH=4 and ready=1, push 0x11, 0x22, 0x33 -> output 0x11, 0x22, 0x33 on consecutive cycles, each one cycle after its push.
REQ-034 Full boundary check: with ready=0, push 0xA0..0xA3 -> level=4, stream_in_ready=0, almost_full=1; a fifth word 0xA4 is not accepted.
REQ-035 Simultaneous push/pop and wrap check: at level 2, run 10 cycles of push+pop -> level stays 2; output sequence is continuous across the pointer wrap.
REQ-036 Backpressure check: hold ready=0 for 5 cycles with 0x5A at the head -> stream_out_data stays 0x5A; with STREAM_BUFFER_STATS_EN, stall_count=5.
REQ-037 Parameter sweep: DATA_WIDTH=64 with DEPTH=2 and DEPTH=256 -> random push/pop traffic matches a reference queue, with no loss and no duplication.

Source files
------------

// File: rtl/stream_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_buffer_pkg
// Purpose  : Shared constants, types and helpers for the stream_buffer block.
//            - STATS_CNT_WIDTH : width of the optional statistics counters
//            - buf_state_e     : occupancy state (EMPTY / PARTIAL / FULL)
//            - level_width()   : bit width needed to hold an occupancy 0..depth
// Revision : 1.0 - initial release
// ============================================================================
package stream_buffer_pkg;

  localparam int STATS_CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } buf_state_e;

  // Occupancy runs 0..depth inclusive, so one bit more than the pointer width.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : stream_buffer_pkg
`default_nettype wire

// File: rtl/stream_buffer_mem.sv
`default_nettype none
// ============================================================================
// Module   : stream_buffer_mem
// Purpose  : Storage array for stream_buffer. One synchronous write port and
//            one asynchronous (combinational) read port. Contents are not
//            reset; the control logic guarantees stale entries are never read
//            as valid data.
// Ports    : clk      - clock, write on rising edge
//            wr_en    - write strobe
//            wr_addr  - write index
//            wr_data  - write payload
//            rd_addr  - read index
//            rd_data  - read payload (combinational from rd_addr)
// Revision : 1.0 - initial release
// ============================================================================
module stream_buffer_mem
  import stream_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule : stream_buffer_mem
`default_nettype wire

// File: rtl/stream_buffer.sv
`default_nettype none
// ============================================================================
// Module   : stream_buffer
// Purpose  : Valid/ready stream FIFO with occupancy level and a registered
//            almost-full flag. One cycle of latency from push to output;
//            no combinational path between the input and output handshakes.
// Ports    : clk              - sole clock, rising edge
//            reset_n          - asynchronous active-low reset
//            stream_in_valid  - upstream word present
//            stream_in_ready  - buffer can accept a word
//            stream_in_data   - upstream payload
//            stream_out_ready - downstream accepts a word
//            stream_out_valid - buffer presents a word
//            stream_out_data  - head-of-buffer payload
//            level            - occupancy 0..DEPTH
//            almost_full      - high when level >= AFULL_LEVEL
//            push_count       - saturating push counter   (STREAM_BUFFER_STATS_EN)
//            stall_count      - saturating stall counter  (STREAM_BUFFER_STATS_EN)
// Config   : define STREAM_BUFFER_STATS_EN to build the statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module stream_buffer
  import stream_buffer_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     stream_in_valid,
  output logic                     stream_in_ready,
  input  logic [DATA_WIDTH-1:0]    stream_in_data,
  input  logic                     stream_out_ready,
  output logic                     stream_out_valid,
  output logic [DATA_WIDTH-1:0]    stream_out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full
`ifdef STREAM_BUFFER_STATS_EN
  ,
  output logic [STATS_CNT_WIDTH-1:0] push_count,
  output logic [STATS_CNT_WIDTH-1:0] stall_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_L = LW'(AFULL_LEVEL);

  buf_state_e      state_q,       state_d;
  logic [LW-1:0]   level_q,       level_d;
  logic [AW-1:0]   wr_ptr_q,      wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q,      rd_ptr_d;
  logic            in_ready_q,    in_ready_d;
  logic            out_valid_q,   out_valid_d;
  logic            almost_full_q, almost_full_d;

  logic push;
  logic pop;

  // Handshakes use only registered flags, so ready never depends on
  // stream_out_ready: a full buffer refuses a word even if it pops that cycle.
  assign push = stream_in_valid & in_ready_q;
  assign pop  = out_valid_q & stream_out_ready;

  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    // Power-of-two depth: natural overflow of the pointers is the modulo wrap.
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    case (state_q)
      ST_EMPTY: begin
        // DEPTH >= 2, so one word never fills the buffer.
        if (push) begin
          state_d = ST_PARTIAL;
        end
      end
      ST_PARTIAL: begin
        if (push && !pop && (level_q == DEPTH_L - LW'(1))) begin
          state_d = ST_FULL;
        end else if (pop && !push && (level_q == LW'(1))) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d = ST_PARTIAL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    in_ready_d    = (state_d != ST_FULL);
    out_valid_d   = (state_d != ST_EMPTY);
    almost_full_d = (level_d >= AFULL_L);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_EMPTY;
      level_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      almost_full_q <= almost_full_d;
    end
  end

  stream_buffer_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (stream_in_data),
    .rd_addr (rd_ptr_q),
    .rd_data (stream_out_data)
  );

  assign stream_in_ready  = in_ready_q;
  assign stream_out_valid = out_valid_q;
  assign level            = level_q;
  assign almost_full      = almost_full_q;

`ifdef STREAM_BUFFER_STATS_EN
  logic [STATS_CNT_WIDTH-1:0] push_count_q,  push_count_d;
  logic [STATS_CNT_WIDTH-1:0] stall_count_q, stall_count_d;
  logic                       stall;

  // A stall is a cycle where a word is offered downstream but not taken.
  assign stall = out_valid_q & ~stream_out_ready;

  always_comb begin
    push_count_d  = push_count_q;
    stall_count_d = stall_count_q;
    if (push && (push_count_q != '1)) begin
      push_count_d = push_count_q + STATS_CNT_WIDTH'(1);
    end
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + STATS_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      push_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      push_count_q  <= push_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign push_count  = push_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule : stream_buffer
`default_nettype wire

// File: tb/tb_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_buffer
// Purpose  : Self-checking bench for stream_buffer. A queue-based model of
//            the DEPTH=4 buffer is compared against the DUT every cycle;
//            directed sequences pin the model with literal expectations.
//            Two DATA_WIDTH=64 instances (DEPTH=2, DEPTH=256) are driven with
//            random traffic and scored against reference queues.
// Config   : honours STREAM_BUFFER_STATS_EN for the statistics ports.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AFULL = DEPTH - 1;
  localparam int SW    = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          in_valid, in_ready, out_ready, out_valid, almost_full;
  logic [DW-1:0] in_data, out_data;
  logic [2:0]    level;

  logic          a_valid, a_iready, a_oready, a_ovalid, a_af;
  logic [SW-1:0] a_data, a_odata;
  logic [1:0]    a_level;

  logic          b_valid, b_iready, b_oready, b_ovalid, b_af;
  logic [SW-1:0] b_data, b_odata;
  logic [8:0]    b_level;

`ifdef STREAM_BUFFER_STATS_EN
  logic [31:0] push_count, stall_count;
  logic [31:0] a_push_count, a_stall_count, b_push_count, b_stall_count;
`endif

  stream_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .stream_in_valid(in_valid), .stream_in_ready(in_ready), .stream_in_data(in_data),
    .stream_out_ready(out_ready), .stream_out_valid(out_valid), .stream_out_data(out_data),
    .level(level), .almost_full(almost_full)
`ifdef STREAM_BUFFER_STATS_EN
    , .push_count(push_count), .stall_count(stall_count)
`endif
  );

  stream_buffer #(.DATA_WIDTH(SW), .DEPTH(2)) u_d2 (
    .clk(clk), .reset_n(reset_n),
    .stream_in_valid(a_valid), .stream_in_ready(a_iready), .stream_in_data(a_data),
    .stream_out_ready(a_oready), .stream_out_valid(a_ovalid), .stream_out_data(a_odata),
    .level(a_level), .almost_full(a_af)
`ifdef STREAM_BUFFER_STATS_EN
    , .push_count(a_push_count), .stall_count(a_stall_count)
`endif
  );

  stream_buffer #(.DATA_WIDTH(SW), .DEPTH(256)) u_d256 (
    .clk(clk), .reset_n(reset_n),
    .stream_in_valid(b_valid), .stream_in_ready(b_iready), .stream_in_data(b_data),
    .stream_out_ready(b_oready), .stream_out_valid(b_ovalid), .stream_out_data(b_odata),
    .level(b_level), .almost_full(b_af)
`ifdef STREAM_BUFFER_STATS_EN
    , .push_count(b_push_count), .stall_count(b_stall_count)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the DEPTH=4 buffer ----------------
  logic [DW-1:0] mq[$];
  bit            m_up;
  longint        m_push;
  longint        m_stall;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_up    = 1'b0;
      m_push  = 0;
      m_stall = 0;
    end else begin
      bit do_push, do_pop;
      do_push = in_valid && m_up && (mq.size() < DEPTH);
      do_pop  = (mq.size() != 0) && out_ready;
      if ((mq.size() != 0) && !out_ready) m_stall++;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(in_data);
        m_push++;
      end
      m_up = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("level", 64'(level), 64'(mq.size()));
      check("in_ready", 64'(in_ready), 64'(m_up && (mq.size() < DEPTH)));
      check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      check("almost_full", 64'(almost_full), 64'(mq.size() >= AFULL));
      if (mq.size() != 0) check("head", 64'(out_data), 64'(mq[0]));
`ifdef STREAM_BUFFER_STATS_EN
      check("push_count", 64'(push_count), 64'(m_push));
      check("stall_count", 64'(stall_count), 64'(m_stall));
`endif
    end
  end

  // Drive one cycle of stimulus; returns at the next falling edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
  endtask

  logic [SW-1:0] aq[$];
  logic [SW-1:0] bq[$];

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    a_valid = 1'b0; a_data = '0; a_oready = 1'b0;
    b_valid = 1'b0; b_data = '0; b_oready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_level", 64'(level), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_afull", 64'(almost_full), 64'd0);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(in_ready), 64'd1);

    // Latency and order with downstream always ready
    step(1'b1, 8'h11, 1'b1);
    check("lat_11", 64'(out_data), 64'h11);
    step(1'b1, 8'h22, 1'b1);
    check("lat_22", 64'(out_data), 64'h22);
    step(1'b1, 8'h33, 1'b1);
    check("lat_33", 64'(out_data), 64'h33);
    check("lat_level", 64'(level), 64'd1);
    step(1'b0, 8'h00, 1'b1);
    check("lat_empty", 64'(out_valid), 64'd0);

    // Fill to the full boundary under backpressure
    step(1'b1, 8'hA0, 1'b0);
    step(1'b1, 8'hA1, 1'b0);
    check("afull_lvl2", 64'(almost_full), 64'd0);
    step(1'b1, 8'hA2, 1'b0);
    check("afull_lvl3", 64'(almost_full), 64'd1);
    step(1'b1, 8'hA3, 1'b0);
    check("full_level", 64'(level), 64'd4);
    check("full_ready", 64'(in_ready), 64'd0);
    check("full_afull", 64'(almost_full), 64'd1);
    step(1'b1, 8'hA4, 1'b0);
    check("full_reject_level", 64'(level), 64'd4);
    check("full_head", 64'(out_data), 64'hA0);
    step(1'b0, 8'h00, 1'b1);
    check("drain_a1", 64'(out_data), 64'hA1);
    step(1'b0, 8'h00, 1'b1);
    check("drain_a2", 64'(out_data), 64'hA2);
    step(1'b0, 8'h00, 1'b1);
    check("drain_a3", 64'(out_data), 64'hA3);
    step(1'b0, 8'h00, 1'b1);
    check("drain_no_a4", 64'(out_valid), 64'd0);

    // Simultaneous push/pop at level 2 across the pointer wrap
    step(1'b1, 8'hB0, 1'b0);
    step(1'b1, 8'hB1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 8'(8'hB0 + k + 1), 1'b1);
      check("pp_level", 64'(level), 64'd2);
      check("pp_head", 64'(out_data), 64'(8'hB0 + k));
    end
    step(1'b0, 8'h00, 1'b1);
    check("pp_tail", 64'(out_data), 64'hBB);
    step(1'b0, 8'h00, 1'b1);
    check("pp_empty", 64'(level), 64'd0);

    // Reset mid-operation at level 3
    step(1'b1, 8'hC1, 1'b0);
    step(1'b1, 8'hC2, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    check("pre_rst_level", 64'(level), 64'd3);
    #2 reset_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    check("mid_rst_level", 64'(level), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("rel_ready", 64'(in_ready), 64'd1);
    check("rel_valid", 64'(out_valid), 64'd0);
    step(1'b0, 8'h00, 1'b1);
    check("rel_no_word", 64'(out_valid), 64'd0);

    // Backpressure: head held stable for 5 stalled cycles
    step(1'b1, 8'h5A, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 8'h00, 1'b0);
      check("bp_head", 64'(out_data), 64'h5A);
      check("bp_valid", 64'(out_valid), 64'd1);
    end
`ifdef STREAM_BUFFER_STATS_EN
    check("bp_stall_count", 64'(stall_count), 64'd5);
    check("bp_push_count", 64'(push_count), 64'd1);
`endif
    step(1'b0, 8'h00, 1'b1);
    check("bp_popped", 64'(level), 64'd0);

    // Random traffic on DATA_WIDTH=64, DEPTH=2 and DEPTH=256
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 1200; c++) begin
        bit pa, qa, pb, qb;
        check("d2_level", 64'(a_level), 64'(aq.size()));
        check("d2_valid", 64'(a_ovalid), 64'(aq.size() != 0));
        check("d2_ready", 64'(a_iready), 64'(aq.size() < 2));
        if (aq.size() != 0) check("d2_head", a_odata, aq[0]);
        check("d256_level", 64'(b_level), 64'(bq.size()));
        check("d256_valid", 64'(b_ovalid), 64'(bq.size() != 0));
        check("d256_ready", 64'(b_iready), 64'(bq.size() < 256));
        if (bq.size() != 0) check("d256_head", b_odata, bq[0]);

        a_valid  = ($urandom_range(0, 99) < ((ph == 0) ? 70 : 35));
        a_data   = {$urandom(), $urandom()};
        a_oready = ($urandom_range(0, 99) < ((ph == 0) ? 40 : 80));
        b_valid  = ($urandom_range(0, 99) < ((ph == 0) ? 70 : 35));
        b_data   = {$urandom(), $urandom()};
        b_oready = ($urandom_range(0, 99) < ((ph == 0) ? 40 : 80));

        pa = a_valid && (aq.size() < 2);
        qa = a_oready && (aq.size() != 0);
        pb = b_valid && (bq.size() < 256);
        qb = b_oready && (bq.size() != 0);
        if (qa) void'(aq.pop_front());
        if (pa) aq.push_back(a_data);
        if (qb) void'(bq.pop_front());
        if (pb) bq.push_back(b_data);
        @(negedge clk);
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_stream_buffer
`default_nettype wire
